mdu_unit: RTL and testbench

- Multiply/divide unit living in the EX stage, beside the ALU, of the 5-stage MIPS pipeline.
- Executes MULT/MULTU/DIV/DIVU over a fixed multi-cycle latency and owns the HI/LO registers (MTHI/MTLO write them, MFHI/MFLO read them).
- Drives busy status into the hazard unit, which stalls the ID stage while a multiply/divide-class instruction waits on the unit.

---
 rtl/mdu_unit_if.sv | 33 +++
 rtl/mdu_unit.sv | 120 ++++++++++++
 tb/tb_mdu_unit.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/mdu_unit_if.sv
`default_nettype none
// ============================================================================
// Module      : mdu_unit_if
// Description : Pipeline <-> multiply/divide unit handshake and HI/LO bus.
//               The cancel signal exists only when MDU_CANCEL_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
interface mdu_unit_if;
    logic        start;
    logic [2:0]  op;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
`ifdef MDU_CANCEL_EN
    logic        cancel;
`endif
    logic        busy;
    logic        md_stall;
    logic [31:0] hi;
    logic [31:0] lo;

`ifdef MDU_CANCEL_EN
    modport master (output start, op, rs_data, rt_data, cancel,
                    input  busy, md_stall, hi, lo);
    modport slave  (input  start, op, rs_data, rt_data, cancel,
                    output busy, md_stall, hi, lo);
`else
    modport master (output start, op, rs_data, rt_data,
                    input  busy, md_stall, hi, lo);
    modport slave  (input  start, op, rs_data, rt_data,
                    output busy, md_stall, hi, lo);
`endif
endinterface
`default_nettype wire

// File: rtl/mdu_unit.sv
`default_nettype none
// ============================================================================
// Module      : mdu_unit
// Description : EX-stage multi-cycle MULT/MULTU/DIV/DIVU unit owning HI/LO.
//               Optional macro MDU_CANCEL_EN adds an abort input.
// Revision    : 1.0 - initial release
// ============================================================================
module mdu_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  wire logic  clk,
    input  wire logic  reset,
    mdu_unit_if.slave  bus
);
    localparam logic [0:0] c_ST_IDLE = 1'b0;
    localparam logic [0:0] c_ST_RUN  = 1'b1;
    localparam logic [4:0] c_MULT_N  = 5'(MULT_CYCLES);
    localparam logic [4:0] c_DIV_N   = 5'(DIV_CYCLES);

    logic [0:0]  r_state, w_state_nxt;
    logic [4:0]  r_count;
    logic [31:0] r_hi, r_lo, r_pend_hi, r_pend_lo;
    logic        r_pend_wr;
    logic        w_busy, w_md_stall;

    logic w_cancel;
`ifdef MDU_CANCEL_EN
    assign w_cancel = bus.cancel;
`else
    assign w_cancel = 1'b0;
`endif

    logic w_is_md, w_is_mul, w_is_div, w_signed, w_idle, w_launch, w_commit, w_abort;
    assign w_is_md  = (bus.op >= 3'd1) && (bus.op <= 3'd4);
    assign w_is_mul = (bus.op == 3'd1) || (bus.op == 3'd2);
    assign w_is_div = (bus.op == 3'd3) || (bus.op == 3'd4);
    assign w_signed = (bus.op == 3'd1) || (bus.op == 3'd3);
    assign w_idle   = (r_state == c_ST_IDLE);
    assign w_launch = w_idle && bus.start && w_is_md && !w_cancel;
    assign w_commit = !w_idle && (r_count == 5'd1) && !w_cancel;
    assign w_abort  = !w_idle && w_cancel;

    // Sign-extending to 64 bits lets one truncated multiply serve both flavours.
    logic [63:0] w_ext_a, w_ext_b, w_prod;
    assign w_ext_a = {{32{w_signed & bus.rs_data[31]}}, bus.rs_data};
    assign w_ext_b = {{32{w_signed & bus.rt_data[31]}}, bus.rt_data};
    assign w_prod  = w_ext_a * w_ext_b;

    // Divide on magnitudes; -2^31 / -1 then wraps naturally to 0x80000000 rem 0.
    logic        w_a_neg, w_b_neg, w_div_zero;
    logic [31:0] w_a_mag, w_b_mag, w_q_mag, w_r_mag, w_quot, w_rem;
    assign w_a_neg    = w_signed & bus.rs_data[31];
    assign w_b_neg    = w_signed & bus.rt_data[31];
    assign w_a_mag    = w_a_neg ? -bus.rs_data : bus.rs_data;
    assign w_b_mag    = w_b_neg ? -bus.rt_data : bus.rt_data;
    assign w_div_zero = (bus.rt_data == 32'd0);
    assign w_q_mag    = w_div_zero ? 32'd0 : (w_a_mag / w_b_mag);
    assign w_r_mag    = w_div_zero ? 32'd0 : (w_a_mag % w_b_mag);
    assign w_quot     = (w_a_neg ^ w_b_neg) ? -w_q_mag : w_q_mag;
    assign w_rem      = w_a_neg ? -w_r_mag : w_r_mag;

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= c_ST_IDLE;
        else       r_state <= w_state_nxt;
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_IDLE: if (w_launch) w_state_nxt = c_ST_RUN;
            c_ST_RUN:  if (w_cancel || (r_count == 5'd1)) w_state_nxt = c_ST_IDLE;
            default:   w_state_nxt = c_ST_IDLE;
        endcase
    end

    // Output logic; start is ignored while reset is held
    always_comb begin
        w_busy     = (r_state == c_ST_RUN);
        w_md_stall = !reset && (w_busy || (bus.start && w_is_md));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count   <= 5'd0;
            r_hi      <= 32'd0;
            r_lo      <= 32'd0;
            r_pend_hi <= 32'd0;
            r_pend_lo <= 32'd0;
            r_pend_wr <= 1'b0;
        end else begin
            if (w_launch) begin
                r_count   <= w_is_mul ? c_MULT_N : c_DIV_N;
                r_pend_hi <= w_is_mul ? w_prod[63:32] : w_rem;
                r_pend_lo <= w_is_mul ? w_prod[31:0]  : w_quot;
                r_pend_wr <= !(w_is_div && w_div_zero);
            end else if (w_abort) begin
                r_count <= 5'd0;
            end else if (!w_idle) begin
                r_count <= r_count - 5'd1;
            end

            if (w_commit && r_pend_wr) begin
                r_hi <= r_pend_hi;
                r_lo <= r_pend_lo;
            end else if (w_idle && bus.start && !w_cancel) begin
                if (bus.op == 3'd5) r_hi <= bus.rs_data;
                if (bus.op == 3'd6) r_lo <= bus.rs_data;
            end
        end
    end

    assign bus.busy     = w_busy;
    assign bus.md_stall = w_md_stall;
    assign bus.hi       = r_hi;
    assign bus.lo       = r_lo;
endmodule
`default_nettype wire

// File: tb/tb_mdu_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_mdu_unit
// Description : Self-checking bench for mdu_unit: directed cases plus random
//               ops against an arithmetic HI/LO model. Honours MDU_CANCEL_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mdu_unit;
    localparam int c_MULT_N = 5;
    localparam int c_DIV_N  = 10;

    logic clk = 1'b0;
    logic reset;
    int   n_checks = 0;
    int   n_errors = 0;
    logic [31:0] m_hi = 32'd0;
    logic [31:0] m_lo = 32'd0;

    mdu_unit_if bus ();

    mdu_unit #(.MULT_CYCLES(c_MULT_N), .DIV_CYCLES(c_DIV_N)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (!reset && bus.busy)
            assert (!bus.start) else $error("start issued while unit busy");
    end

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Architectural result of one op, straight from 64-bit integer arithmetic.
    function automatic void ref_apply(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        longint p, q, r;
        case (op)
            3'd1: begin p = longint'($signed(a)) * longint'($signed(b)); m_hi = p[63:32]; m_lo = p[31:0]; end
            3'd2: begin p = longint'({32'd0, a}) * longint'({32'd0, b}); m_hi = p[63:32]; m_lo = p[31:0]; end
            3'd3: if (b != 0) begin
                      q = longint'($signed(a)) / longint'($signed(b));
                      r = longint'($signed(a)) % longint'($signed(b));
                      m_hi = r[31:0]; m_lo = q[31:0];
                  end
            3'd4: if (b != 0) begin
                      q = longint'({32'd0, a}) / longint'({32'd0, b});
                      r = longint'({32'd0, a}) % longint'({32'd0, b});
                      m_hi = r[31:0]; m_lo = q[31:0];
                  end
            3'd5: m_hi = a;
            3'd6: m_lo = a;
            default: ;
        endcase
    endfunction

    // Called at a negedge with the unit idle; returns at a negedge, idle again.
    task automatic run_md(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        int n;
        logic [31:0] old_hi, old_lo;
        n = (op <= 3'd2) ? c_MULT_N : c_DIV_N;
        old_hi = m_hi;
        old_lo = m_lo;
        ref_apply(op, a, b);
        bus.start = 1'b1; bus.op = op; bus.rs_data = a; bus.rt_data = b;
        #1;
        check_eq("stall_c0", bus.md_stall, 1);
        check_eq("busy_c0", bus.busy, 0);
        @(negedge clk);
        bus.start = 1'b0; bus.op = 3'd0;
        for (int i = 1; i <= n; i++) begin
            check_eq("busy_run", bus.busy, 1);
            check_eq("stall_run", bus.md_stall, 1);
            check_eq("hi_hold", bus.hi, old_hi);
            check_eq("lo_hold", bus.lo, old_lo);
            @(negedge clk);
        end
        check_eq("busy_done", bus.busy, 0);
        check_eq("hi_done", bus.hi, m_hi);
        check_eq("lo_done", bus.lo, m_lo);
    endtask

    task automatic run_single(input logic [2:0] op, input logic [31:0] a);
        ref_apply(op, a, 32'd0);
        bus.start = 1'b1; bus.op = op; bus.rs_data = a; bus.rt_data = $urandom;
        #1;
        check_eq("stall_single", bus.md_stall, 0);
        @(negedge clk);
        bus.start = 1'b0; bus.op = 3'd0;
        check_eq("busy_single", bus.busy, 0);
        check_eq("hi_single", bus.hi, m_hi);
        check_eq("lo_single", bus.lo, m_lo);
    endtask

    function automatic logic [31:0] rand_val();
        case ($urandom_range(0, 5))
            0:       return 32'd0;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'($urandom_range(0, 15));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [2:0] op;
        reset = 1'b1;
        bus.start = 1'b1; bus.op = 3'd1; bus.rs_data = 32'd3; bus.rt_data = 32'd4;
`ifdef MDU_CANCEL_EN
        bus.cancel = 1'b0;
`endif
        @(negedge clk); @(negedge clk);
        check_eq("rst_busy", bus.busy, 0);
        check_eq("rst_stall", bus.md_stall, 0);
        check_eq("rst_hi", bus.hi, 0);
        check_eq("rst_lo", bus.lo, 0);
        bus.start = 1'b0; bus.op = 3'd0;
        reset = 1'b0;
        @(negedge clk);

        run_md(3'd1, 32'hFFFF_FFFE, 32'd3);
        check_eq("mult_hi", bus.hi, 32'hFFFF_FFFF);
        check_eq("mult_lo", bus.lo, 32'hFFFF_FFFA);
        run_md(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        check_eq("multu_hi", bus.hi, 32'hFFFF_FFFE);
        check_eq("multu_lo", bus.lo, 32'h0000_0001);
        run_md(3'd3, 32'hFFFF_FFF9, 32'd2);
        check_eq("div_hi", bus.hi, 32'hFFFF_FFFF);
        check_eq("div_lo", bus.lo, 32'hFFFF_FFFD);
        run_md(3'd4, 32'hFFFF_FFF9, 32'd2);
        check_eq("divu_hi", bus.hi, 32'd1);
        check_eq("divu_lo", bus.lo, 32'h7FFF_FFFC);
        run_md(3'd3, 32'h8000_0000, 32'hFFFF_FFFF);
        check_eq("ovf_hi", bus.hi, 32'd0);
        check_eq("ovf_lo", bus.lo, 32'h8000_0000);

        run_single(3'd5, 32'h11);
        run_single(3'd6, 32'h22);
        run_md(3'd3, 32'd55, 32'd0);
        check_eq("dz_hi", bus.hi, 32'h11);
        check_eq("dz_lo", bus.lo, 32'h22);

        run_single(3'd6, 32'h1234);
        check_eq("mtlo_lo", bus.lo, 32'h1234);

        // Reset asserted in the third busy cycle of a mult.
        bus.start = 1'b1; bus.op = 3'd1; bus.rs_data = 32'd7; bus.rt_data = 32'd9;
        @(negedge clk);
        bus.start = 1'b0; bus.op = 3'd0;
        @(negedge clk); @(negedge clk);
        check_eq("pre_rst_busy", bus.busy, 1);
        reset = 1'b1;
        #1;
        check_eq("midrst_busy", bus.busy, 0);
        check_eq("midrst_hi", bus.hi, 0);
        check_eq("midrst_lo", bus.lo, 0);
        m_hi = 32'd0; m_lo = 32'd0;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check_eq("postrst_busy", bus.busy, 0);
        check_eq("postrst_lo", bus.lo, 0);

`ifdef MDU_CANCEL_EN
        run_single(3'd5, 32'hAA);
        run_single(3'd6, 32'hBB);
        bus.start = 1'b1; bus.op = 3'd3; bus.rs_data = 32'd100; bus.rt_data = 32'd7;
        @(negedge clk);
        bus.start = 1'b0; bus.op = 3'd0;
        for (int i = 1; i <= 3; i++) @(negedge clk);
        check_eq("cyc4_busy", bus.busy, 1);
        bus.cancel = 1'b1;
        @(negedge clk);
        bus.cancel = 1'b0;
        check_eq("cancel_busy", bus.busy, 0);
        check_eq("cancel_hi", bus.hi, 32'hAA);
        check_eq("cancel_lo", bus.lo, 32'hBB);
        bus.start = 1'b1; bus.op = 3'd5; bus.rs_data = 32'h5555; bus.cancel = 1'b1;
        @(negedge clk);
        bus.start = 1'b0; bus.op = 3'd0; bus.cancel = 1'b0;
        check_eq("cancel_mthi", bus.hi, 32'hAA);
        run_md(3'd4, 32'd100, 32'd7);
        check_eq("divu_c_hi", bus.hi, 32'd2);
        check_eq("divu_c_lo", bus.lo, 32'd14);
`endif

        for (int k = 0; k < 40; k++) begin
            op = 3'($urandom_range(0, 7));
            if (op >= 3'd1 && op <= 3'd4) begin
                run_md(op, rand_val(), rand_val());
            end else if (op == 3'd5 || op == 3'd6) begin
                run_single(op, rand_val());
            end else begin
                bus.start = 1'b1; bus.op = op; bus.rs_data = $urandom; bus.rt_data = $urandom;
                #1;
                check_eq("nop_stall", bus.md_stall, 0);
                @(negedge clk);
                bus.start = 1'b0; bus.op = 3'd0;
                check_eq("nop_busy", bus.busy, 0);
                check_eq("nop_hi", bus.hi, m_hi);
                check_eq("nop_lo", bus.lo, m_lo);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
`default_nettype wire
